// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: default fetch geometry, fetch FSM states, NOP word.
package cpu_pkg;

  localparam int unsigned DEF_PC_W     = 12;
  localparam logic [11:0] DEF_RESET_PC = 12'h000;
  localparam logic [31:0] NOP          = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_hold_buf.sv
// Parking register for a fetched {pc_4, instruction} while decode is stalled.
module if_hold_buf #(
  parameter int unsigned W = 44
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         inval,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] data_q, data_d;

  // Invalidate wins over load so a redirect never leaves a stale word behind.
  always_comb begin
    data_d = data_q;
    if (inval)     data_d = '0;
    else if (load) data_d = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem handshake, parks words across
// decode stalls and applies redirects as a cleared IF/ID load.
module if_fetch_stage
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W     = DEF_PC_W,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEF_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_target,
  input  logic            halt,
  output logic [PC_W-1:0] pc_4,
  output logic [31:0]     instruction,
  output logic            go,
  output logic            clear
);

  localparam int unsigned HB_W = PC_W + 32;
  localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_plus4;
  logic [PC_W-1:0] last_pc4_q, last_pc4_d;
  logic [31:0]     last_instr_q, last_instr_d;
  logic [PC_W-1:0] pres_pc4;
  logic [31:0]     pres_instr;
  logic            req_c, go_c, clear_c;
  logic            hold_load, hold_inval;
  logic [HB_W-1:0] hold_q;

  assign pc_plus4 = pc_q + PC_W'(4);

  if_hold_buf #(.W(HB_W)) u_hold_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (hold_load),
    .inval (hold_inval),
    .d     ({pc_plus4, imem_rdata}),
    .q     (hold_q)
  );

  // Next-state, next-PC and handshake decode.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_c      = 1'b0;
    go_c       = 1'b0;
    clear_c    = 1'b0;
    hold_load  = 1'b0;
    hold_inval = 1'b0;
    pres_pc4   = last_pc4_q;
    pres_instr = last_instr_q;

    case (state_q)
      FETCH: begin
        req_c = 1'b1;
        if (redirect) begin
          go_c       = 1'b1;
          clear_c    = 1'b1;
          pres_instr = NOP;
          hold_inval = 1'b1;
          pc_d       = redirect_target & ALIGN_MASK;
        end else if (imem_ack && !stall) begin
          go_c       = 1'b1;
          pres_instr = imem_rdata;
          pres_pc4   = pc_plus4;
          pc_d       = pc_plus4;
        end else if (imem_ack) begin
          hold_load = 1'b1;
          state_d   = HOLD;
        end
        if (halt) state_d = HALT;
      end

      HOLD: begin
        pres_pc4   = hold_q[HB_W-1:32];
        pres_instr = hold_q[31:0];
        if (redirect) begin
          go_c       = 1'b1;
          clear_c    = 1'b1;
          pres_instr = NOP;
          pres_pc4   = last_pc4_q;
          hold_inval = 1'b1;
          pc_d       = redirect_target & ALIGN_MASK;
          state_d    = FETCH;
        end else if (!stall) begin
          go_c    = 1'b1;
          pc_d    = pc_plus4;
          state_d = FETCH;
        end
        if (halt) state_d = HALT;
      end

      HALT: state_d = HALT;

      default: state_d = FETCH;
    endcase
  end

  assign last_pc4_d   = go_c ? pres_pc4   : last_pc4_q;
  assign last_instr_d = go_c ? pres_instr : last_instr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC & ALIGN_MASK;
      last_pc4_q   <= '0;
      last_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      last_pc4_q   <= last_pc4_d;
      last_instr_q <= last_instr_d;
    end
  end

  // Handshake strobes are forced low while reset is held.
  assign imem_req    = req_c & rst_n;
  assign go          = go_c & rst_n;
  assign clear       = clear_c & rst_n;
  assign imem_addr   = pc_q;
  assign pc_4        = pres_pc4;
  assign instruction = pres_instr;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: directed per-cycle vectors, negedge monitor.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic [11:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [11:0] redirect_target;
  logic        halt;
  logic [11:0] pc_4;
  logic [31:0] instruction;
  logic        go;
  logic        clear;

  if_fetch_stage #(.PC_W(12), .RESET_PC(12'h000)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_addr       (imem_addr),
    .imem_req        (imem_req),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .halt            (halt),
    .pc_4            (pc_4),
    .instruction     (instruction),
    .go              (go),
    .clear           (clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        chk_addr;
    logic [11:0] addr;
    logic        req;
    logic        go;
    logic        clr;
    logic        chk_data;
    logic [31:0] instr;
    logic [11:0] pc4;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.name, "imem_req", 32'(imem_req), 32'(e.req));
      check(e.name, "go",       32'(go),       32'(e.go));
      check(e.name, "clear",    32'(clear),    32'(e.clr));
      if (e.chk_addr) check(e.name, "imem_addr", 32'(imem_addr), 32'(e.addr));
      if (e.chk_data) begin
        check(e.name, "instruction", instruction, e.instr);
        check(e.name, "pc_4",        32'(pc_4),   32'(e.pc4));
      end
    end
  end

  task automatic step(input string nm, input logic ack, input logic [31:0] rdata,
                      input logic stl, input logic redir, input logic [11:0] tgt,
                      input logic hlt, input logic e_req, input logic [11:0] e_addr,
                      input logic e_go, input logic e_clr, input logic e_chk,
                      input logic [31:0] e_instr, input logic [11:0] e_pc4);
    exp_t e;
    rst_n           = 1'b1;
    imem_ack        = ack;
    imem_rdata      = rdata;
    stall           = stl;
    redirect        = redir;
    redirect_target = tgt;
    halt            = hlt;
    e.name = nm; e.chk_addr = e_req; e.addr = e_addr; e.req = e_req;
    e.go = e_go; e.clr = e_clr; e.chk_data = e_chk; e.instr = e_instr; e.pc4 = e_pc4;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input string nm);
    exp_t e;
    rst_n    = 1'b0;
    imem_ack = 1'b1;
    stall    = 1'b0;
    redirect = 1'b0;
    halt     = 1'b0;
    e.name = nm; e.chk_addr = 1'b1; e.addr = 12'h000; e.req = 1'b0;
    e.go = 1'b0; e.clr = 1'b0; e.chk_data = 1'b0; e.instr = '0; e.pc4 = '0;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; stall = 1'b0;
    redirect = 1'b0; redirect_target = '0; halt = 1'b0;
    @(posedge clk); #1;
    do_reset("reset");

    // Streaming fetch, ack every cycle
    step("seq0", 1, 32'h1000_0001, 0, 0, 12'h0, 0, 1, 12'h000, 1, 0, 1, 32'h1000_0001, 12'h004);
    step("seq1", 1, 32'h1000_0002, 0, 0, 12'h0, 0, 1, 12'h004, 1, 0, 1, 32'h1000_0002, 12'h008);
    step("seq2", 1, 32'h1000_0003, 0, 0, 12'h0, 0, 1, 12'h008, 1, 0, 1, 32'h1000_0003, 12'h00C);
    step("seq3", 1, 32'h1000_0004, 0, 0, 12'h0, 0, 1, 12'h00C, 1, 0, 1, 32'h1000_0004, 12'h010);

    // Three wait states at 0x010
    for (int i = 0; i < 3; i++)
      step("wait", 0, 32'hBAD0_0000, 0, 0, 12'h0, 0, 1, 12'h010, 0, 0, 0, 32'h0, 12'h0);
    step("wait_ack", 1, 32'h1000_0005, 0, 0, 12'h0, 0, 1, 12'h010, 1, 0, 1, 32'h1000_0005, 12'h014);
    step("seq4", 1, 32'h1000_0006, 0, 0, 12'h0, 0, 1, 12'h014, 1, 0, 1, 32'h1000_0006, 12'h018);
    step("seq5", 1, 32'h1000_0007, 0, 0, 12'h0, 0, 1, 12'h018, 1, 0, 1, 32'h1000_0007, 12'h01C);
    step("seq6", 1, 32'h1000_0008, 0, 0, 12'h0, 0, 1, 12'h01C, 1, 0, 1, 32'h1000_0008, 12'h020);

    // Stall with ack at 0x020: park, then release
    step("stall_ack",  1, 32'h8C01_0004, 1, 0, 12'h0, 0, 1, 12'h020, 0, 0, 0, 32'h0, 12'h0);
    step("hold_stall", 1, 32'h5555_5555, 1, 0, 12'h0, 0, 0, 12'h000, 0, 0, 0, 32'h0, 12'h0);
    step("hold_rel",   1, 32'h6666_6666, 0, 0, 12'h0, 0, 0, 12'h000, 1, 0, 1, 32'h8C01_0004, 12'h024);
    step("after_hold", 1, 32'h1000_0009, 0, 0, 12'h0, 0, 1, 12'h024, 1, 0, 1, 32'h1000_0009, 12'h028);

    // Redirect while parked and stalled: bubble, held word dropped
    step("park2",      1, 32'hDEAD_BEEF, 1, 0, 12'h0,   0, 1, 12'h028, 0, 0, 0, 32'h0, 12'h0);
    step("redir_hold", 1, 32'h7777_7777, 1, 1, 12'h103, 0, 0, 12'h000, 1, 1, 0, 32'h0, 12'h0);
    step("tgt_wait",   0, 32'hDEAD_BEEF, 0, 0, 12'h0,   0, 1, 12'h100, 0, 0, 0, 32'h0, 12'h0);
    step("tgt_fetch",  1, 32'h1000_00AA, 0, 0, 12'h0,   0, 1, 12'h100, 1, 0, 1, 32'h1000_00AA, 12'h104);

    // Redirect from FETCH to 0xFFC discarding same-cycle ack, then wrap
    step("redir_fetch", 1, 32'h9999_9999, 1, 1, 12'hFFC, 0, 1, 12'h104, 1, 1, 0, 32'h0, 12'h0);
    step("wrap",        1, 32'h1000_0077, 0, 0, 12'h0,   0, 1, 12'hFFC, 1, 0, 1, 32'h1000_0077, 12'h000);
    step("wrap_next",   0, 32'h0,         0, 0, 12'h0,   0, 1, 12'h000, 0, 0, 0, 32'h0, 12'h0);

    // Halt completes current fetch, then sticky even under redirect
    step("halt_go", 1, 32'h1000_0088, 0, 0, 12'h0,   1, 1, 12'h000, 1, 0, 1, 32'h1000_0088, 12'h004);
    step("halted0", 1, 32'h1000_0099, 0, 1, 12'h200, 0, 0, 12'h000, 0, 0, 0, 32'h0, 12'h0);
    step("halted1", 1, 32'h1000_0099, 0, 1, 12'h200, 1, 0, 12'h000, 0, 0, 0, 32'h0, 12'h0);

    // Reset mid-halt returns PC to RESET_PC
    do_reset("reset_halt");
    step("post_rst", 1, 32'h1000_00BB, 0, 0, 12'h0, 0, 1, 12'h000, 1, 0, 1, 32'h1000_00BB, 12'h004);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
